// File: rtl/led_pkg.sv
// Shared encodings for the status-LED arbiter: display modes, FSM states and
// the default prescaler for a 50 MHz board clock.
package led_pkg;

  typedef enum logic [1:0] {
    ModeOff   = 2'b00,
    ModeSolid = 2'b01,
    ModeSlow  = 2'b10,
    ModeFast  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StShow = 2'b01,
    StOpen = 2'b10
  } state_e;

  // 50 MHz / 3125000 = 16 Hz tick.
  localparam int unsigned DefaultTickDiv = 3125000;

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler: emits a one-cycle tick every TICK_DIV clocks.
module led_tick_gen #(
  parameter int unsigned TICK_DIV = 3125000
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CntMax);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_blink_arbiter.sv
// Fixed-priority arbiter sharing one status LED between NREQ requesters, with a
// minimum hold time per grant and registered blink pattern / busy outputs.
module led_blink_arbiter
  import led_pkg::*;
#(
  parameter int unsigned NREQ           = 4,
  parameter int unsigned TICK_DIV       = DefaultTickDiv,
  parameter int unsigned MIN_HOLD_TICKS = 8,
  parameter int unsigned ID_W           = 2
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] mode,
  output logic [NREQ-1:0]   ack,
  output logic [ID_W-1:0]   active_id,
  output logic [1:0]        LEDG
);

  localparam int unsigned HoldW = (MIN_HOLD_TICKS > 0) ? $clog2(MIN_HOLD_TICKS + 1) : 1;
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MIN_HOLD_TICKS);

  logic tick;

  led_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .CLOCK_50(CLOCK_50),
    .RESET_N (RESET_N),
    .tick    (tick)
  );

  state_e           state_q, state_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  mode_e            mode_q, mode_d;
  logic [3:0]       phase_q, phase_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [ID_W-1:0]  active_id_q, active_id_d;
  logic [1:0]       led_q, led_d;

  logic [ID_W-1:0]  winner;
  logic             grant;
  logic             busy;
  logic             pattern;

  always_comb begin
    winner = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) winner = ID_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    mode_d  = mode_q;
    phase_d = phase_q;
    hold_d  = hold_q;
    grant   = 1'b0;

    if (tick) begin
      phase_d = phase_q + 4'd1;
      if (hold_q != HoldMax) hold_d = hold_q + 1'b1;
    end

    // Follow the owner's mode live; once its req drops, mode_q keeps the last value.
    if (state_q != StIdle && req[owner_q]) begin
      mode_d = mode_e'(mode[2*int'(owner_q) +: 2]);
    end

    case (state_q)
      StIdle: if (|req) grant = 1'b1;
      StShow: if (hold_q == HoldMax) state_d = StOpen;
      StOpen: begin
        if (!(|req)) state_d = StIdle;
        else if (winner != owner_q) grant = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // A new grant restarts the blink ON and wins over a coincident tick.
    if (grant) begin
      state_d = StShow;
      owner_d = winner;
      mode_d  = mode_e'(mode[2*int'(winner) +: 2]);
      phase_d = '0;
      hold_d  = '0;
    end

    case (mode_d)
      ModeOff:   pattern = 1'b0;
      ModeSolid: pattern = 1'b1;
      ModeSlow:  pattern = ~phase_d[3];
      ModeFast:  pattern = ~phase_d[1];
      default:   pattern = 1'b0;
    endcase

    busy        = (state_d != StIdle);
    ack_d       = busy ? (NREQ'(1) << owner_d) : '0;
    active_id_d = busy ? owner_d : '0;
    led_d       = busy ? {1'b1, pattern} : 2'b00;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      mode_q      <= ModeOff;
      phase_q     <= '0;
      hold_q      <= '0;
      ack_q       <= '0;
      active_id_q <= '0;
      led_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mode_q      <= mode_d;
      phase_q     <= phase_d;
      hold_q      <= hold_d;
      ack_q       <= ack_d;
      active_id_q <= active_id_d;
      led_q       <= led_d;
    end
  end

  assign ack       = ack_q;
  assign active_id = active_id_q;
  assign LEDG      = led_q;

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Randomized bench for led_blink_arbiter against a tick-count reference model.
module tb_led_blink_arbiter;

  localparam int unsigned NReq    = 4;
  localparam int unsigned TickDiv = 4;
  localparam int unsigned MinHold = 2;
  localparam int unsigned IdW     = 2;

  logic             clk;
  logic             rst_n;
  logic [NReq-1:0]  req;
  logic [2*NReq-1:0] mode;
  logic [NReq-1:0]  ack;
  logic [IdW-1:0]   active_id;
  logic [1:0]       ledg;

  led_blink_arbiter #(
    .NREQ          (NReq),
    .TICK_DIV      (TickDiv),
    .MIN_HOLD_TICKS(MinHold),
    .ID_W          (IdW)
  ) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .req      (req),
    .mode     (mode),
    .ack      (ack),
    .active_id(active_id),
    .LEDG     (ledg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: time measured in ticks since the current grant.
  int m_tcnt  = 0;   // cycles within the tick period
  int m_stage = 0;   // 0 idle, 1 minimum hold running, 2 open for re-arbitration
  int m_owner = 0;
  int m_ticks = 0;   // ticks since grant
  int m_mode  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit tick;
    bit any;
    bit grant;
    int win;
    int next_stage;
    if (!rst_n) begin
      m_tcnt = 0; m_stage = 0; m_owner = 0; m_ticks = 0; m_mode = 0;
      return;
    end
    tick   = (m_tcnt == TickDiv - 1);
    m_tcnt = (m_tcnt + 1) % TickDiv;
    any = 1'b0;
    win = 0;
    for (int i = 0; i < NReq; i++) begin
      if (req[i] && !any) begin
        any = 1'b1;
        win = i;
      end
    end
    if (m_stage != 0 && req[m_owner]) m_mode = int'(mode[2*m_owner +: 2]);
    grant      = 1'b0;
    next_stage = m_stage;
    case (m_stage)
      0: if (any) grant = 1'b1;
      1: if (((m_ticks < MinHold) ? m_ticks : MinHold) == MinHold) next_stage = 2;
      default: begin
        if (!any) next_stage = 0;
        else if (win != m_owner) grant = 1'b1;
      end
    endcase
    if (tick) m_ticks++;
    if (grant) begin
      m_owner    = win;
      m_mode     = int'(mode[2*win +: 2]);
      m_ticks    = 0;
      next_stage = 1;
    end
    m_stage = next_stage;
  endtask

  task automatic check_outputs();
    bit   busy;
    logic pat;
    busy = (m_stage != 0);
    case (m_mode)
      0:       pat = 1'b0;
      1:       pat = 1'b1;
      2:       pat = ((m_ticks % 16) < 8);
      default: pat = ((m_ticks % 4) < 2);
    endcase
    check_eq("ack", 32'(ack), busy ? (32'd1 << m_owner) : 32'd0);
    check_eq("active_id", 32'(active_id), busy ? 32'(m_owner) : 32'd0);
    check_eq("ledg", 32'(ledg), busy ? {30'd0, 1'b1, pat} : 32'd0);
  endtask

  task automatic cyc(input logic r_n, input logic [NReq-1:0] r, input logic [2*NReq-1:0] m,
                     input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst_n = r_n;
      req   = r;
      mode  = m;
      @(posedge clk);
      model_step();
      #1;
      check_outputs();
    end
  endtask

  initial begin
    logic [NReq-1:0]   r;
    logic [2*NReq-1:0] m;
    rst_n = 1'b0;
    req   = '0;
    mode  = '0;

    // Reset holds everything low even with all requests up.
    cyc(1'b0, 4'b1111, 8'hff, 3);
    // Slow blink on requester 2.
    cyc(1'b1, 4'b0100, 8'b00_10_00_00, 80);
    cyc(1'b1, 4'b0000, 8'h00, 4);
    // Simultaneous requests resolve to the lower index.
    cyc(1'b1, 4'b1010, 8'b11_01_11_01, 20);
    cyc(1'b1, 4'b0000, 8'h00, 4);
    // Higher priority arrives during the minimum hold; no preemption.
    cyc(1'b1, 4'b1000, 8'b11_00_00_10, 1);
    cyc(1'b1, 4'b1001, 8'b11_00_00_10, 30);
    cyc(1'b1, 4'b0000, 8'h00, 4);
    // Owner drops right after grant; latched mode persists, then idle.
    cyc(1'b1, 4'b0010, 8'b00_00_11_00, 1);
    cyc(1'b1, 4'b0000, 8'b00_00_01_00, 20);
    // Reset mid fast blink with req held.
    cyc(1'b1, 4'b1000, 8'b11_00_00_00, 10);
    cyc(1'b0, 4'b1000, 8'b11_00_00_00, 1);
    cyc(1'b1, 4'b1000, 8'b11_00_00_00, 20);

    r = '0;
    m = '0;
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(7) == 0) r = NReq'($urandom);
      if ($urandom_range(7) == 0) m = (2*NReq)'($urandom);
      cyc(($urandom_range(199) != 0), r, m, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
